sram_arbiter: RTL
=================

# sram_arbiter

Shares the single-ported base SRAM between the instruction-fetch port and the MEM-stage data port. It runs a multi-cycle SRAM access state machine, drives the SRAM control pins, returns read data, and raises a stall request to the pipeline controller while any requester is waiting. It sits beside the EX/MEM → MEM path. MEM-stage stores of bytes and words (byte-enable form) and loads arrive here, as do all instruction fetches.

## Interface
- WAIT_CYCLES, 1: SRAM access length in cycles beyond the first; legal range 1..15.
- ADDR_W, 20: SRAM word-address width.

- clk  in  1  system clock, all state on posedge.
- rst  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held with if_addr until if_ready.
- if_addr  in  32  byte address of the fetch.
- if_rdata  out  32  fetched word; valid while if_ready is high.
- if_ready  out  1  one-cycle completion pulse for the fetch.
- mem_req  in  1  data request; held with its fields until mem_ready.
- mem_we  in  1  1 = store, 0 = load.
- mem_be  in  4  active-high byte enables for a store: one-hot for sb, 4'b1111 for sw.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  store data, already lane-aligned.
- mem_rdata  out  32  load word; valid while mem_ready is high.
- mem_ready  out  1  one-cycle completion pulse for the data access.
- sram_addr  out  ADDR_W  word address.
- sram_wdata  out  32  write data.
- sram_rdata  in  32  read data.
- sram_ce_n, sram_oe_n, sram_we_n  out  1  active-low chip enable, output enable and write enable.
- sram_be_n  out  4  active-low byte enables.
- stall_req  out  1  pipeline stall request.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE arbitration:
  - mem_req wins over if_req, because the MEM-stage instruction is older.
  - The winner's address, we, be and wdata are latched, and the state moves to ACCESS.
  - With no request, the state stays in IDLE.
- ACCESS:
  - Lasts WAIT_CYCLES+1 cycles, counted by a 4-bit down-counter loaded with WAIT_CYCLES. The state exits to DONE when the counter is 0.
  - sram_ce_n = 0 for the whole access.
  - sram_addr = latched addr[ADDR_W+1:2].
  - Read (any IF access, or MEM with we=0): sram_oe_n = 0, sram_be_n = 4'b0000. sram_rdata is captured on the final ACCESS edge.
  - Write: sram_oe_n = 1 and sram_be_n = ~be. sram_we_n = 0 in every ACCESS cycle except the first, which is address setup. sram_wdata is driven from the latched data for all of ACCESS and DONE.
- DONE:
  - sram_we_n = 1 and sram_oe_n = 1; sram_ce_n, addr, be_n and wdata stay held.
  - The served port's ready is 1 and its rdata is presented from the capture register (write: rdata = 0).
  - The state always returns to IDLE; there is no back-to-back grant from DONE.
- stall_req = (mem_req & ~mem_ready) | (if_req & ~if_ready), combinational.
- A requester drops or renews its req in the cycle after its ready; the arbiter does not re-check fields after latching.
- Starvation: IF can be delayed by at most one MEM access per instruction, since the pipeline is stalled meanwhile. No fairness counter is needed.

## Timing
- Reset (rst = 0, asynchronous):
  - State goes to IDLE and the counter to 0.
  - if_ready = mem_ready = 0 and if_rdata = mem_rdata = 0.
  - sram_ce_n = sram_oe_n = sram_we_n = 1 and sram_be_n = 4'hF.
  - sram_addr = 0 and sram_wdata = 0.
- Reset mid-access aborts it immediately: the SRAM pins go inactive in the same instant and no ready is issued. After release, a still-asserted req is re-arbitrated from IDLE.
- Latency, with the request present in IDLE at cycle 0:
  - ACCESS runs in cycles 1..WAIT_CYCLES+1.
  - ready is high in cycle WAIT_CYCLES+2.
  - IDLE is reached in cycle WAIT_CYCLES+3.
- Throughput: one access per WAIT_CYCLES+3 cycles.
- Simultaneous requests in IDLE: MEM is served first. The IF request is granted on the IDLE cycle that follows MEM's DONE.
- All SRAM outputs are registered, so there are no combinational paths from req to the pins.

## Test plan
- Reset: hold rst = 0 for 3 cycles, then release → all outputs at their reset values, stall_req = 0 with no requests.
- IF read, WAIT_CYCLES = 1: if_addr = 0x80000010, sram_rdata = 0xDEADBEEF → sram_addr = 0x00004 and oe_n = 0 in cycles 1-2; if_ready = 1 with if_rdata = 0xDEADBEEF in cycle 3; stall_req = 1 in cycles 0-2.
- MEM sb: mem_addr = 0x80400003, mem_be = 4'b1000, mem_wdata = 0x11000000 → sram_be_n = 4'b0111; we_n = 0 only in cycle 2; mem_ready in cycle 3; no if_ready.
- Contention: if_req and mem_req (load) both raised at cycle 0 → mem_ready in cycle 3, IF ACCESS in cycles 5-6, if_ready in cycle 7; stall_req = 1 in cycles 0-6 and 0 in cycle 7.
- Reset mid-write: assert rst during ACCESS cycle 2 → sram_we_n and sram_ce_n return to 1 asynchronously; no mem_ready; after release with mem_req held, the full access repeats and mem_ready arrives 3 cycles after the first IDLE.
- WAIT_CYCLES = 3 read → oe_n = 0 in cycles 1-4, ready in cycle 5.

Source files
------------

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - arbitrates the shared single-ported SRAM between fetch and MEM-stage data
// MEM beats IF in IDLE; all SRAM pins and ready/rdata outputs are registered from next-state values.
module sram_arbiter #(
    parameter int WAIT_CYCLES = 1,
    parameter int ADDR_W      = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic [31:0]       if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [3:0]        mem_be,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic [31:0]       mem_rdata,
    output logic              mem_ready,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic [3:0]        sram_be_n,
    output logic              stall_req
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                sel_mem_q, sel_mem_d;
    logic                we_q, we_d;
    logic [3:0]          be_q, be_d;
    logic [ADDR_W-1:0]   sram_addr_q, sram_addr_d;
    logic [31:0]         sram_wdata_q, sram_wdata_d;
    logic                sram_ce_n_q, sram_ce_n_d;
    logic                sram_oe_n_q, sram_oe_n_d;
    logic                sram_we_n_q, sram_we_n_d;
    logic [3:0]          sram_be_n_q, sram_be_n_d;
    logic                if_ready_q, if_ready_d;
    logic                mem_ready_q, mem_ready_d;
    logic [31:0]         if_rdata_q, if_rdata_d;
    logic [31:0]         mem_rdata_q, mem_rdata_d;
    logic [31:0]         capture;

    // Only the word-address bits of the byte addresses reach the SRAM.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                mem_addr[31:ADDR_W+2], mem_addr[1:0]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            sel_mem_q    <= 1'b0;
            we_q         <= 1'b0;
            be_q         <= 4'd0;
            sram_addr_q  <= '0;
            sram_wdata_q <= 32'd0;
            sram_ce_n_q  <= 1'b1;
            sram_oe_n_q  <= 1'b1;
            sram_we_n_q  <= 1'b1;
            sram_be_n_q  <= 4'hF;
            if_ready_q   <= 1'b0;
            mem_ready_q  <= 1'b0;
            if_rdata_q   <= 32'd0;
            mem_rdata_q  <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            sel_mem_q    <= sel_mem_d;
            we_q         <= we_d;
            be_q         <= be_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            sram_ce_n_q  <= sram_ce_n_d;
            sram_oe_n_q  <= sram_oe_n_d;
            sram_we_n_q  <= sram_we_n_d;
            sram_be_n_q  <= sram_be_n_d;
            if_ready_q   <= if_ready_d;
            mem_ready_q  <= mem_ready_d;
            if_rdata_q   <= if_rdata_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        sel_mem_d    = sel_mem_q;
        we_d         = we_q;
        be_d         = be_q;
        sram_addr_d  = sram_addr_q;
        sram_wdata_d = sram_wdata_q;
        case (state_q)
            S_IDLE: begin
                if (mem_req) begin
                    state_d      = S_ACCESS;
                    cnt_d        = WAIT_INIT;
                    sel_mem_d    = 1'b1;
                    we_d         = mem_we;
                    be_d         = mem_be;
                    sram_addr_d  = mem_addr[ADDR_W+1:2];
                    sram_wdata_d = mem_wdata;
                end else if (if_req) begin
                    state_d      = S_ACCESS;
                    cnt_d        = WAIT_INIT;
                    sel_mem_d    = 1'b0;
                    we_d         = 1'b0;
                    be_d         = 4'd0;
                    sram_addr_d  = if_addr[ADDR_W+1:2];
                    sram_wdata_d = 32'd0;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin values are computed for the cycle being entered so the registered pins line up with the state.
    always_comb begin
        capture     = (state_q == S_ACCESS && cnt_q == 4'd0 && !we_q) ? sram_rdata : 32'd0;
        sram_ce_n_d = (state_d == S_IDLE);
        sram_oe_n_d = !(state_d == S_ACCESS && !we_d);
        sram_we_n_d = !(state_d == S_ACCESS && state_q == S_ACCESS && we_d);
        sram_be_n_d = 4'hF;
        if (state_d != S_IDLE) begin
            sram_be_n_d = we_d ? ~be_d : 4'b0000;
        end
        if_ready_d  = (state_d == S_DONE) && !sel_mem_d;
        mem_ready_d = (state_d == S_DONE) && sel_mem_d;
        if_rdata_d  = if_ready_d ? capture : 32'd0;
        mem_rdata_d = mem_ready_d ? capture : 32'd0;
    end

    assign sram_addr  = sram_addr_q;
    assign sram_wdata = sram_wdata_q;
    assign sram_ce_n  = sram_ce_n_q;
    assign sram_oe_n  = sram_oe_n_q;
    assign sram_we_n  = sram_we_n_q;
    assign sram_be_n  = sram_be_n_q;
    assign if_ready   = if_ready_q;
    assign mem_ready  = mem_ready_q;
    assign if_rdata   = if_rdata_q;
    assign mem_rdata  = mem_rdata_q;
    assign stall_req  = (mem_req & ~mem_ready_q) | (if_req & ~if_ready_q);

endmodule
